// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch (IF) and load/store (LS), one transaction in flight.
// Optional IF anti-starvation guard is enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,

    input  logic                ls_req_valid,
    input  logic                ls_req_we,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_req_ready,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_data,

    output logic                mem_req_valid,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_req_ready,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t state;
    logic   owner_if;
    logic   grant_if;
    logic   grant_ls;
    logic   force_if;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign force_if = if_req_valid && (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts back-to-back LS wins that left IF waiting; saturates so IF stays forced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_ls && if_req_valid) begin
            if (starve_cnt != CNT_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end
        end else if (grant_if || grant_ls) begin
            starve_cnt <= '0;
        end
    end
`else
    logic unused_cfg;

    assign force_if   = 1'b0;
    assign unused_cfg = (STARVE_MAX > 0);
`endif

    // Grants exist only in IDLE, and are masked by reset so ready is 0 while rst is high.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (!rst && state == IDLE) begin
            if (ls_req_valid && !force_if) begin
                grant_ls = 1'b1;
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            owner_if      <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_ls) begin
                        owner_if      <= 1'b0;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= ls_req_we;
                        mem_req_addr  <= ls_req_addr;
                        mem_req_wdata <= ls_req_wdata;
                        mem_req_wmask <= ls_req_wmask;
                        state         <= REQ;
                    end else if (grant_if) begin
                        owner_if      <= 1'b1;
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= if_req_addr;
                        mem_req_wdata <= '0;
                        mem_req_wmask <= '0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_resp_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    mem_req_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    // Responses outside WAIT (stale or early) never reach a requester.
    assign if_resp_valid = (state == WAIT) && mem_resp_valid && owner_if;
    assign ls_resp_valid = (state == WAIT) && mem_resp_valid && !owner_if;
    assign if_resp_data  = rst ? '0 : mem_resp_data;
    assign ls_resp_data  = rst ? '0 : mem_resp_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset/starvation sequences, and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 64;
    localparam int STARVE_MAX = 4;
    localparam logic [63:0] A_IF = 64'h8000_0000;
    localparam logic [63:0] A_LS = 64'h0000_1000;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              ls_req_valid;
    logic              ls_req_we;
    logic [ADDR_W-1:0] ls_req_addr;
    logic [DATA_W-1:0] ls_req_wdata;
    logic [7:0]        ls_req_wmask;
    logic              ls_req_ready;
    logic              ls_resp_valid;
    logic [DATA_W-1:0] ls_resp_data;
    logic              mem_req_valid;
    logic              mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [7:0]        mem_req_wmask;
    logic              mem_req_ready;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        if_v;
        logic        ls_v;
        logic        ls_we;
        logic        mem_rdy;
        logic        mem_rsp;
        logic        e_if_rdy;
        logic        e_ls_rdy;
        logic        e_mem_v;
        logic        e_mem_we;
        logic        e_if_rsp;
        logic        e_ls_rsp;
        logic [63:0] e_addr;
        logic [7:0]  e_wmask;
    } vec_t;

    vec_t vecs[$];

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_we     (ls_req_we),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_wmask  (ls_req_wmask),
        .ls_req_ready  (ls_req_ready),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_data  (ls_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_we    (mem_req_we),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wmask (mem_req_wmask),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic ifv, input logic lsv, input logic lswe,
                                input logic mrdy, input logic mrsp, input logic eifr, input logic elsr,
                                input logic emv, input logic emwe, input logic eifrsp, input logic elsrsp,
                                input logic [63:0] eaddr, input logic [7:0] ewm);
        vec_t v;
        v.rst = r;       v.if_v = ifv;     v.ls_v = lsv;       v.ls_we = lswe;
        v.mem_rdy = mrdy; v.mem_rsp = mrsp;
        v.e_if_rdy = eifr; v.e_ls_rdy = elsr; v.e_mem_v = emv; v.e_mem_we = emwe;
        v.e_if_rsp = eifrsp; v.e_ls_rsp = elsrsp; v.e_addr = eaddr; v.e_wmask = ewm;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        if_req_valid   = 1'b0;
        if_req_addr    = '0;
        ls_req_valid   = 1'b0;
        ls_req_we      = 1'b0;
        ls_req_addr    = '0;
        ls_req_wdata   = '0;
        ls_req_wmask   = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    task automatic pulseReset();
        nextCycle();
        idleInputs();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        if_req_valid   = v.if_v;
        if_req_addr    = A_IF;
        ls_req_valid   = v.ls_v;
        ls_req_we      = v.ls_we;
        ls_req_addr    = A_LS;
        ls_req_wdata   = 64'hAB;
        ls_req_wmask   = 8'h01;
        mem_req_ready  = v.mem_rdy;
        mem_resp_valid = v.mem_rsp;
        mem_resp_data  = 64'h13;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".if_req_ready"},  if_req_ready,  0);
        checkOutput({tag, ".ls_req_ready"},  ls_req_ready,  0);
        checkOutput({tag, ".if_resp_valid"}, if_resp_valid, 0);
        checkOutput({tag, ".ls_resp_valid"}, ls_resp_valid, 0);
        checkOutput({tag, ".if_resp_data"},  if_resp_data,  0);
        checkOutput({tag, ".ls_resp_data"},  ls_resp_data,  0);
        checkOutput({tag, ".mem_req_valid"}, mem_req_valid, 0);
        checkOutput({tag, ".mem_req_we"},    mem_req_we,    0);
        checkOutput({tag, ".mem_req_addr"},  mem_req_addr,  0);
        checkOutput({tag, ".mem_req_wdata"}, mem_req_wdata, 0);
        checkOutput({tag, ".mem_req_wmask"}, mem_req_wmask, 0);
    endtask

    task automatic checkRow(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("row%0d", idx);
        if (v.rst) begin
            checkAllZero(tag);
        end else begin
            checkOutput({tag, ".if_req_ready"},  if_req_ready,  v.e_if_rdy);
            checkOutput({tag, ".ls_req_ready"},  ls_req_ready,  v.e_ls_rdy);
            checkOutput({tag, ".mem_req_valid"}, mem_req_valid, v.e_mem_v);
            checkOutput({tag, ".if_resp_valid"}, if_resp_valid, v.e_if_rsp);
            checkOutput({tag, ".ls_resp_valid"}, ls_resp_valid, v.e_ls_rsp);
            if (v.e_mem_v) begin
                checkOutput({tag, ".mem_req_we"},    mem_req_we,    v.e_mem_we);
                checkOutput({tag, ".mem_req_addr"},  mem_req_addr,  v.e_addr);
                checkOutput({tag, ".mem_req_wmask"}, mem_req_wmask, v.e_wmask);
                checkOutput({tag, ".mem_req_wdata"}, mem_req_wdata, (v.e_addr == A_LS) ? 64'hAB : 64'h0);
            end
            if (v.e_if_rsp) checkOutput({tag, ".if_resp_data"}, if_resp_data, 64'h13);
            if (v.e_ls_rsp) checkOutput({tag, ".ls_resp_data"}, ls_resp_data, 64'h13);
        end
    endtask

    task automatic starveTest();
        int  ls_grants;
        bit  if_granted;
        pulseReset();
        ls_grants  = 0;
        if_granted = 1'b0;
        for (int c = 0; c < 60 && !if_granted; c++) begin
            nextCycle();
            if_req_valid   = 1'b1;
            if_req_addr    = A_IF;
            ls_req_valid   = 1'b1;
            ls_req_we      = 1'($urandom_range(0, 1));
            ls_req_addr    = A_LS;
            mem_req_ready  = 1'b1;
            mem_resp_valid = 1'b1;
            #3;
            if (if_req_ready) if_granted = 1'b1;
            else if (ls_req_ready) ls_grants++;
        end
        checkOutput("starve.if_granted", if_granted, GUARD_ON);
        checkOutput("starve.ls_grants", ls_grants, GUARD_ON ? 4 : 20);
    endtask

    task automatic resetInWaitTest();
        pulseReset();
        nextCycle(); if_req_valid = 1'b1; if_req_addr = A_IF;
        #3; checkOutput("rstwait.if_req_ready", if_req_ready, 1);
        nextCycle(); if_req_valid = 1'b0; mem_req_ready = 1'b1;
        #3; checkOutput("rstwait.mem_req_valid", mem_req_valid, 1);
        nextCycle(); mem_req_ready = 1'b0; rst = 1'b1;
        #3; checkAllZero("rstwait.in_reset");
        nextCycle(); rst = 1'b0;
        nextCycle(); mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD;
        #3;
        checkOutput("rstwait.if_resp_valid", if_resp_valid, 0);
        checkOutput("rstwait.ls_resp_valid", ls_resp_valid, 0);
        checkOutput("rstwait.mem_req_valid", mem_req_valid, 0);
        nextCycle(); mem_resp_valid = 1'b0; ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = A_LS;
        #3; checkOutput("rstwait.ls_req_ready", ls_req_ready, 1);
        nextCycle(); ls_req_valid = 1'b0; mem_req_ready = 1'b1;
        #3;
        checkOutput("rstwait.mem_req_valid2", mem_req_valid, 1);
        checkOutput("rstwait.mem_req_addr", mem_req_addr, A_LS);
        nextCycle(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h5A;
        #3;
        checkOutput("rstwait.ls_resp_valid2", ls_resp_valid, 1);
        checkOutput("rstwait.ls_resp_data", ls_resp_data, 64'h5A);
        checkOutput("rstwait.if_resp_valid2", if_resp_valid, 0);
        nextCycle(); mem_resp_valid = 1'b0;
    endtask

    // Reference model: one outstanding-transaction slot plus a starvation tally.
    task automatic randomTest(input int cycles);
        bit          busy = 0, sent = 0, own_if = 0, if_hold = 0, ls_hold = 0;
        bit          e_gif, e_gls, e_mv, e_ifr, e_lsr, force_if;
        logic        s_we = 0;
        logic [63:0] s_addr = 0, s_wdata = 0;
        logic [7:0]  s_wmask = 0;
        int          starve = 0;
        pulseReset();
        for (int c = 0; c < cycles; c++) begin
            nextCycle();
            if (if_hold) begin
                if_req_valid = ($urandom_range(0, 7) != 0);
            end else begin
                if_req_valid = 1'($urandom_range(0, 1));
                if_req_addr  = {$urandom, $urandom};
            end
            if (ls_hold) begin
                ls_req_valid = ($urandom_range(0, 7) != 0);
            end else begin
                ls_req_valid = 1'($urandom_range(0, 1));
                ls_req_we    = 1'($urandom_range(0, 1));
                ls_req_addr  = {$urandom, $urandom};
                ls_req_wdata = {$urandom, $urandom};
                ls_req_wmask = 8'($urandom_range(0, 255));
            end
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = {$urandom, $urandom};

            e_gif = 0;
            e_gls = 0;
            if (!busy) begin
                force_if = GUARD_ON && if_req_valid && (starve >= STARVE_MAX);
                if (ls_req_valid && !force_if) e_gls = 1;
                else if (if_req_valid) e_gif = 1;
            end
            e_mv  = busy && !sent;
            e_ifr = busy && sent && mem_resp_valid && own_if;
            e_lsr = busy && sent && mem_resp_valid && !own_if;

            #3;
            checkOutput("rnd.if_req_ready",  if_req_ready,  e_gif);
            checkOutput("rnd.ls_req_ready",  ls_req_ready,  e_gls);
            checkOutput("rnd.mem_req_valid", mem_req_valid, e_mv);
            checkOutput("rnd.if_resp_valid", if_resp_valid, e_ifr);
            checkOutput("rnd.ls_resp_valid", ls_resp_valid, e_lsr);
            if (e_mv) begin
                checkOutput("rnd.mem_req_we",    mem_req_we,    s_we);
                checkOutput("rnd.mem_req_addr",  mem_req_addr,  s_addr);
                checkOutput("rnd.mem_req_wdata", mem_req_wdata, s_wdata);
                checkOutput("rnd.mem_req_wmask", mem_req_wmask, s_wmask);
            end
            if (e_ifr) checkOutput("rnd.if_resp_data", if_resp_data, mem_resp_data);
            if (e_lsr) checkOutput("rnd.ls_resp_data", ls_resp_data, mem_resp_data);

            if (e_gls) begin
                busy = 1; sent = 0; own_if = 0;
                s_we = ls_req_we; s_addr = ls_req_addr; s_wdata = ls_req_wdata; s_wmask = ls_req_wmask;
                starve = if_req_valid ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
            end else if (e_gif) begin
                busy = 1; sent = 0; own_if = 1;
                s_we = 0; s_addr = if_req_addr; s_wdata = 0; s_wmask = 0;
                starve = 0;
            end else if (e_mv && mem_req_ready) begin
                sent = 1;
            end else if (busy && sent && mem_resp_valid) begin
                busy = 0;
            end
            if_hold = if_req_valid && !e_gif;
            ls_hold = ls_req_valid && !e_gls;
        end
    endtask

    initial begin
        // Directed vector table: one entry per clock cycle.
        vecs.push_back(mk(1,1,1,1,1,1, 0,0,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,1,0,0,0,0, 1,0,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,0,0,0, A_IF,  8'h00));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,1,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,1,1,1,0,0, 0,1,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,1,0,0,1,0, 0,0,1,1,0,0, A_LS,  8'h01));
        vecs.push_back(mk(0,1,0,0,0,1, 0,0,0,0,0,1, 64'h0, 8'h00));
        vecs.push_back(mk(0,1,0,0,0,0, 1,0,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,0,0,0, A_IF,  8'h00));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,1,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,0,1,0,0,0, 0,1,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,1,0,0,0, A_LS,  8'h01));
        vecs.push_back(mk(0,1,0,0,0,1, 0,0,1,0,0,0, A_LS,  8'h01));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,1,0,0,0, A_LS,  8'h01));
        vecs.push_back(mk(0,1,0,0,0,1, 0,0,1,0,0,0, A_LS,  8'h01));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,1,0,0,0, A_LS,  8'h01));
        vecs.push_back(mk(0,1,0,0,1,0, 0,0,1,0,0,0, A_LS,  8'h01));
        vecs.push_back(mk(0,1,0,0,0,0, 0,0,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,1,0,0,0,1, 0,0,0,0,0,1, 64'h0, 8'h00));
        vecs.push_back(mk(0,1,0,0,0,0, 1,0,0,0,0,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,0,0,0, A_IF,  8'h00));
        vecs.push_back(mk(0,0,0,0,0,1, 0,0,0,0,1,0, 64'h0, 8'h00));
        vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,0,0,0, 64'h0, 8'h00));

        rst = 1'b1;
        idleInputs();
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset with random inputs");
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            rst            = 1'b1;
            if_req_valid   = 1'($urandom_range(0, 1));
            if_req_addr    = {$urandom, $urandom};
            ls_req_valid   = 1'($urandom_range(0, 1));
            ls_req_we      = 1'($urandom_range(0, 1));
            ls_req_addr    = {$urandom, $urandom};
            ls_req_wdata   = {$urandom, $urandom};
            ls_req_wmask   = 8'($urandom_range(0, 255));
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_resp_data  = {$urandom, $urandom};
            #3;
            checkAllZero($sformatf("reset%0d", i));
        end

        $display("[TB] directed vector table");
        for (int i = 0; i < vecs.size(); i++) begin
            nextCycle();
            applyStimulus(vecs[i]);
            #3;
            checkRow(vecs[i], i);
        end

        $display("[TB] starvation sequence");
        starveTest();

        $display("[TB] reset during WAIT");
        resetInWaitTest();

        $display("[TB] randomized run against reference model");
        randomTest(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
